// File: rtl/microwave_sequencer_pkg.sv
// microwave_pkg: shared state encoding, BCD digit type and default timing values.
package microwave_pkg;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTING = 3'd1,
        COOKING = 3'd2,
        PAUSED  = 3'd3,
        DONE    = 3'd4
    } state_t;
    typedef logic [3:0] digit_t;
    localparam int QUICK_SEC_DEF  = 30;
    localparam int BEEP_TICKS_DEF = 3;
endpackage

// File: rtl/microwave_sequencer_if.sv
// microwave_sequencer_if: front-panel inputs and magnetron/display outputs of the sequencer.
interface microwave_sequencer_if;
    import microwave_pkg::*;
    logic start, stop, clear, closed_door, key_valid, tick;
    digit_t key_digit;
    logic magnetron, beep;
    digit_t min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state_o;
    modport slave (
        input  start, stop, clear, closed_door, key_valid, key_digit, tick,
        output magnetron, beep, min_tens, min_ones, sec_tens, sec_ones, state_o
    );
    modport master (
        output start, stop, clear, closed_door, key_valid, key_digit, tick,
        input  magnetron, beep, min_tens, min_ones, sec_tens, sec_ones, state_o
    );
endinterface

// File: rtl/microwave_sequencer_counter.sv
// bcd_mmss_counter: 4-digit mm:ss BCD register with clear, quick load, keypad shift and countdown.
module bcd_mmss_counter
    import microwave_pkg::*;
#(
    parameter int QUICK_SEC = QUICK_SEC_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clr,
    input  logic   load_quick,
    input  logic   shift_in,
    input  digit_t digit,
    input  logic   dec,
    output digit_t min_tens,
    output digit_t min_ones,
    output digit_t sec_tens,
    output digit_t sec_ones,
    output logic   is_zero,
    output logic   is_one
);
    assign is_zero = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0000;
    assign is_one  = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0001;

    // Seconds borrow from 0 to 5x (not 9x) so entered values like 99 still count down literally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
        end else if (load_quick) begin
            {min_tens, min_ones} <= 8'h00;
            sec_tens <= digit_t'(QUICK_SEC / 10);
            sec_ones <= digit_t'(QUICK_SEC % 10);
        end else if (shift_in) begin
            {min_tens, min_ones, sec_tens, sec_ones} <= {min_ones, sec_tens, sec_ones, digit};
        end else if (dec && !is_zero) begin
            if (sec_ones != 4'd0) begin
                sec_ones <= sec_ones - 4'd1;
            end else begin
                sec_ones <= 4'd9;
                if (sec_tens != 4'd0) begin
                    sec_tens <= sec_tens - 4'd1;
                end else begin
                    sec_tens <= 4'd5;
                    if (min_ones != 4'd0) begin
                        min_ones <= min_ones - 4'd1;
                    end else begin
                        min_ones <= 4'd9;
                        min_tens <= min_tens - 4'd1;
                    end
                end
            end
        end
    end
endmodule

// File: rtl/microwave_sequencer.sv
// microwave_sequencer: cook-cycle FSM with door/stop interlock, keypad entry, countdown and end beep.
module microwave_sequencer
    import microwave_pkg::*;
#(
    parameter int QUICK_SEC  = QUICK_SEC_DEF,
    parameter int BEEP_TICKS = BEEP_TICKS_DEF
) (
    input logic clk,
    input logic reset,
    microwave_sequencer_if.slave bus
);
    state_t state;
    logic [3:0] beep_cnt;
    logic beep_r, halt, go, entry, key_ok, clr, load_quick, dec, is_zero, is_one;

    assign halt       = bus.stop | ~bus.closed_door;
    assign go         = bus.start & ~halt;
    assign entry      = (state == IDLE) | (state == SETTING);
    assign key_ok     = entry & ~bus.clear & ~go & bus.key_valid & (bus.key_digit <= 4'd9);
    assign load_quick = entry & ~bus.clear & go & is_zero;
    assign dec        = (state == COOKING) & ~halt & bus.tick;
    assign clr        = (entry & bus.clear)
                      | ((state == PAUSED) & ~halt & bus.clear)
                      | ((state == DONE) & (bus.clear | ~bus.closed_door));

    assign bus.magnetron = state == COOKING;
    assign bus.state_o   = state;
    assign bus.beep      = beep_r;

    bcd_mmss_counter #(.QUICK_SEC(QUICK_SEC)) counter (
        .clk        (clk),
        .reset      (reset),
        .clr        (clr),
        .load_quick (load_quick),
        .shift_in   (key_ok),
        .digit      (bus.key_digit),
        .dec        (dec),
        .min_tens   (bus.min_tens),
        .min_ones   (bus.min_ones),
        .sec_tens   (bus.sec_tens),
        .sec_ones   (bus.sec_ones),
        .is_zero    (is_zero),
        .is_one     (is_one)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            beep_r   <= 1'b0;
            beep_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE, SETTING: begin
                    if (bus.clear) state <= IDLE;
                    else if (go) state <= COOKING;
                    else if (key_ok) state <= SETTING;
                end
                COOKING: begin
                    if (halt) begin
                        state <= PAUSED;
                    end else if (bus.tick && (is_one || is_zero)) begin
                        state    <= DONE;
                        beep_r   <= 1'b1;
                        beep_cnt <= 4'd0;
                    end
                end
                PAUSED: begin
                    if (!halt && bus.clear) state <= IDLE;
                    else if (go) state <= COOKING;
                end
                DONE: begin
                    if (bus.clear || !bus.closed_door) begin
                        state  <= IDLE;
                        beep_r <= 1'b0;
                    end else if (bus.tick && beep_r) begin
                        beep_cnt <= beep_cnt + 4'd1;
                        if (beep_cnt + 4'd1 == 4'(BEEP_TICKS)) beep_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_microwave_sequencer.sv
// tb_microwave_sequencer: directed plan plus random panel activity against a seconds-arithmetic model.
module tb_microwave_sequencer;
    localparam int QUICK = 30;
    localparam int BEEPS = 3;
    localparam int S_IDLE = 0, S_SET = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

    logic clk = 1'b0;
    logic reset;
    microwave_sequencer_if bus();
    microwave_sequencer #(.QUICK_SEC(QUICK), .BEEP_TICKS(BEEPS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    int m_state, m_t, m_bc;
    bit m_beep;

    function automatic logic [15:0] bcd(int t);
        logic [15:0] r;
        r[15:12] = 4'(t / 1000);
        r[11:8]  = 4'((t / 100) % 10);
        r[7:4]   = 4'((t / 10) % 10);
        r[3:0]   = 4'(t % 10);
        return r;
    endfunction

    function automatic logic [15:0] disp();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".state"}, 16'(bus.state_o), 16'(m_state));
        check({tag, ".mag"}, 16'(bus.magnetron), 16'(m_state == S_COOK));
        check({tag, ".time"}, disp(), bcd(m_t));
        check({tag, ".beep"}, 16'(bus.beep), 16'(m_beep));
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_t = 0;
        m_bc = 0;
        m_beep = 0;
    endtask

    // Time held as decimal mmss; a borrow from :00 subtracts one minute and adds 59 seconds.
    task automatic model_step();
        bit halt;
        halt = bus.stop || !bus.closed_door;
        case (m_state)
            S_IDLE, S_SET: begin
                if (bus.clear) begin
                    m_state = S_IDLE;
                    m_t = 0;
                end else if (bus.start && !halt) begin
                    if (m_t == 0) m_t = QUICK;
                    m_state = S_COOK;
                end else if (bus.key_valid && bus.key_digit <= 9) begin
                    m_t = (m_t * 10 + int'(bus.key_digit)) % 10000;
                    m_state = S_SET;
                end
            end
            S_COOK: begin
                if (halt) m_state = S_PAUSE;
                else if (bus.tick) begin
                    if (m_t % 100 > 0) m_t = m_t - 1;
                    else if (m_t > 0) m_t = m_t - 41;
                    if (m_t == 0) begin
                        m_state = S_DONE;
                        m_beep = 1;
                        m_bc = 0;
                    end
                end
            end
            S_PAUSE: begin
                if (!halt && bus.clear) begin
                    m_state = S_IDLE;
                    m_t = 0;
                end else if (!halt && bus.start) m_state = S_COOK;
            end
            default: begin
                if (bus.clear || !bus.closed_door) begin
                    m_state = S_IDLE;
                    m_t = 0;
                    m_beep = 0;
                end else if (bus.tick && m_beep) begin
                    m_bc++;
                    if (m_bc == BEEPS) m_beep = 0;
                end
            end
        endcase
    endtask

    task automatic cyc(int st, int sp, int cl, int dr, int kv, int kd, int tk, string tag = "cyc");
        bus.start = 1'(st);
        bus.stop = 1'(sp);
        bus.clear = 1'(cl);
        bus.closed_door = 1'(dr);
        bus.key_valid = 1'(kv);
        bus.key_digit = 4'(kd);
        bus.tick = 1'(tk);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic key(int d);
        cyc(0, 0, 0, 1, 1, d, 0, "key");
    endtask

    task automatic press_start();
        cyc(1, 0, 0, 1, 0, 0, 0, "start");
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 1, "tick");
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.stop = 0; bus.clear = 0; bus.closed_door = 1;
        bus.key_valid = 0; bus.key_digit = 0; bus.tick = 0;
        model_reset();
        #2;
        check_all("reset");
        check("rst_time", disp(), 16'h0000);
        check("rst_state", 16'(bus.state_o), 16'd0);
        @(negedge clk);
        reset = 1'b0;

        key(1); key(12); key(0); key(5);
        check("keys105", disp(), 16'h0105);
        check("keys_state", 16'(bus.state_o), 16'd1);
        press_start();
        check("cook105_state", 16'(bus.state_o), 16'd2);
        check("cook105_mag", 16'(bus.magnetron), 16'd1);
        ticks(6);
        check("t0059", disp(), 16'h0059);
        ticks(59);
        check("t0000", disp(), 16'h0000);
        check("done_state", 16'(bus.state_o), 16'd4);
        check("done_mag", 16'(bus.magnetron), 16'd0);
        check("beep_on", 16'(bus.beep), 16'd1);
        ticks(2);
        check("beep_hold", 16'(bus.beep), 16'd1);
        ticks(1);
        check("beep_off", 16'(bus.beep), 16'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, "done_door");
        check("done_door_state", 16'(bus.state_o), 16'd0);

        key(2); key(0); press_start();
        check("t0020", disp(), 16'h0020);
        cyc(0, 0, 0, 0, 0, 0, 1, "door_tick");
        cyc(0, 0, 0, 0, 0, 0, 1, "door_tick");
        check("pause_state", 16'(bus.state_o), 16'd3);
        check("pause_time", disp(), 16'h0020);
        check("pause_mag", 16'(bus.magnetron), 16'd0);
        press_start();
        check("resume_state", 16'(bus.state_o), 16'd2);
        ticks(1);
        check("t0019", disp(), 16'h0019);
        cyc(0, 1, 0, 1, 0, 0, 0, "stop");
        cyc(0, 0, 1, 1, 0, 0, 0, "pause_clear");
        check("pclear_state", 16'(bus.state_o), 16'd0);
        check("pclear_time", disp(), 16'h0000);

        press_start();
        check("quick_time", disp(), 16'h0030);
        check("quick_state", 16'(bus.state_o), 16'd2);
        cyc(0, 0, 1, 1, 0, 0, 0, "cook_clear");
        check("cook_clear_mag", 16'(bus.magnetron), 16'd1);
        cyc(0, 1, 0, 1, 0, 0, 0, "stop");
        cyc(1, 1, 0, 1, 0, 0, 0, "start_stop");
        check("start_stop_state", 16'(bus.state_o), 16'd3);
        cyc(0, 0, 1, 1, 0, 0, 0, "pause_clear");
        cyc(1, 0, 0, 0, 0, 0, 0, "start_open");
        check("start_open_state", 16'(bus.state_o), 16'd0);

        key(9); key(9); key(9); key(9);
        check("t9999", disp(), 16'h9999);
        press_start();
        ticks(1);
        check("t9998", disp(), 16'h9998);
        ticks(98);
        check("t9900", disp(), 16'h9900);
        ticks(1);
        check("t9859", disp(), 16'h9859);

        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_mag", 16'(bus.magnetron), 16'd0);
        check("async_state", 16'(bus.state_o), 16'd0);
        check("async_time", disp(), 16'h0000);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 3000; i++)
            cyc(int'($urandom % 6 == 0), int'($urandom % 20 == 0), int'($urandom % 25 == 0),
                int'($urandom % 12 != 0), int'($urandom % 3 == 0), int'($urandom % 16),
                int'($urandom % 3 == 0), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
